// File: rtl/sm_key_step.sv
// ---------------------------------------------------------------------------
// sm_key_step
//   Turns a raw, bouncy, active-low push-button into clean single-cycle
//   pulses. The debounced level is also exported, together with one-cycle
//   press and release pulses. An optional auto-repeat fires while the button
//   is held. The step output is the registered OR of press and repeat. On the
//   board it drives the clock divider enable for manual single-stepping.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a new input value must hold before it is accepted (>= 1)
//   REPEAT_DELAY     cycles from accepted press to first repeat pulse (0 = no repeat)
//   REPEAT_PERIOD    cycles between successive repeat pulses (>= 1)
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   key_n        raw button, asynchronous, 0 = pressed
//   key_level    debounced state, 1 = pressed
//   key_press    one-cycle pulse on accepted press
//   key_release  one-cycle pulse on accepted release
//   key_repeat   one-cycle auto-repeat pulse while held
//   step         key_press | key_repeat, registered
// ---------------------------------------------------------------------------
module sm_key_step #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic step
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 32'd1);

  // Counters compare against "last value before the target": the edge that
  // would make the count reach its target is the edge that fires.
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(32'd1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'((REPEAT_DELAY == 32'd0) ? 32'd0 : (REPEAT_DELAY - 32'd1));
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 32'd1);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(32'd1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } state_t;

  logic             sync1_r;
  logic             sync_r;
  logic [DB_W-1:0]  db_cnt_r;
  logic [DB_W-1:0]  db_cnt_nxt_s;
  logic             accept_s;
  logic             press_s;
  logic             release_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [RPT_W-1:0] rpt_cnt_r;
  logic [RPT_W-1:0] rpt_cnt_nxt_s;
  logic             repeat_s;

  // Two-flop synchronizer on the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync_r  <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync_r  <= sync1_r;
    end
  end

  // Debounce counter next state and acceptance decision.
  always_comb begin
    db_cnt_nxt_s = '0;
    accept_s     = 1'b0;
    // sync is active-low and key_level active-high, so equal bits mean the
    // input disagrees with the accepted state.
    if (sync_r == key_level) begin
      if (db_cnt_r == DB_LAST) begin
        accept_s     = 1'b1;
        db_cnt_nxt_s = '0;
      end else begin
        db_cnt_nxt_s = db_cnt_r + DB_ONE;
      end
    end else begin
      db_cnt_nxt_s = '0;
    end
  end

  assign press_s   = accept_s & ~key_level;
  assign release_s = accept_s &  key_level;

  // Debounced level and press/release pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_r    <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      db_cnt_r    <= db_cnt_nxt_s;
      key_level   <= key_level ^ accept_s;
      key_press   <= press_s;
      key_release <= release_s;
    end
  end

  // Repeat FSM next state, repeat counter and repeat pulse condition.
  always_comb begin
    state_nxt_s   = state_r;
    rpt_cnt_nxt_s = rpt_cnt_r;
    repeat_s      = 1'b0;
    if (release_s) begin
      // Release wins over a repeat due on the same edge.
      state_nxt_s   = RELEASED;
      rpt_cnt_nxt_s = '0;
      repeat_s      = 1'b0;
    end else begin
      case (state_r)
        RELEASED: begin
          rpt_cnt_nxt_s = '0;
          if (press_s) begin
            state_nxt_s = HOLD_DELAY;
          end else begin
            state_nxt_s = RELEASED;
          end
        end
        HOLD_DELAY: begin
          if (REPEAT_DELAY == 32'd0) begin
            // Auto-repeat disabled: park here until release.
            rpt_cnt_nxt_s = '0;
          end else if (rpt_cnt_r == DELAY_LAST) begin
            repeat_s      = 1'b1;
            rpt_cnt_nxt_s = '0;
            state_nxt_s   = HOLD_REPEAT;
          end else begin
            rpt_cnt_nxt_s = rpt_cnt_r + RPT_ONE;
          end
        end
        HOLD_REPEAT: begin
          if (rpt_cnt_r == PERIOD_LAST) begin
            repeat_s      = 1'b1;
            rpt_cnt_nxt_s = '0;
          end else begin
            rpt_cnt_nxt_s = rpt_cnt_r + RPT_ONE;
          end
        end
        default: begin
          state_nxt_s   = RELEASED;
          rpt_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // Repeat FSM state, counter, repeat pulse and step registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RELEASED;
      rpt_cnt_r  <= '0;
      key_repeat <= 1'b0;
      step       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rpt_cnt_r  <= rpt_cnt_nxt_s;
      key_repeat <= repeat_s;
      step       <= press_s | repeat_s;
    end
  end

endmodule

// File: tb/tb_sm_key_step.sv
// ---------------------------------------------------------------------------
// tb_sm_key_step
//   Self-checking bench for sm_key_step. Two instances share clk/rst/key_n.
//   One has auto-repeat (DEBOUNCE=4, DELAY=10, PERIOD=3). The other has
//   repeat disabled (DELAY=0). Expected outputs come from a window model:
//   the accepted level flips once the last DEBOUNCE sync samples since reset
//   all disagree with it. Repeats fall at press + DELAY + n*PERIOD while the
//   button is held.
// ---------------------------------------------------------------------------
module tb_sm_key_step;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  logic key_n;
  logic key_level, key_press, key_release, key_repeat, step;
  logic z_level, z_press, z_release, z_repeat, z_step;

  always #5 clk = ~clk;

  sm_key_step #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .step(step)
  );

  sm_key_step #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut_norep (
    .clk(clk), .rst(rst), .key_n(key_n),
    .key_level(z_level), .key_press(z_press), .key_release(z_release),
    .key_repeat(z_repeat), .step(z_step)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit samp[$];      // sync value seen at each edge since reset (two reset 1s first)
  int edge_no;      // edges since reset release
  bit m_level;
  int press_edge;
  bit e_press, e_release, e_repeat;

  function automatic void model_reset();
    samp = '{1'b1, 1'b1};
    edge_no = 0;
    m_level = 1'b0;
    press_edge = 0;
    e_press = 1'b0;
    e_release = 1'b0;
    e_repeat = 1'b0;
  endfunction

  function automatic void model_edge();
    bit toggle;
    bit was;
    edge_no++;
    toggle = (edge_no >= DB);
    if (toggle) begin
      // Active-low sample equal to the active-high level means disagreement.
      for (int j = edge_no - DB; j < edge_no; j++)
        if (samp[j] != m_level) toggle = 1'b0;
    end
    was = m_level;
    e_press = toggle && !was;
    e_release = toggle && was;
    if (toggle) m_level = !was;
    if (e_press) press_edge = edge_no;
    e_repeat = m_level && !e_press && (RD > 0) && ((edge_no - press_edge) >= RD)
               && (((edge_no - press_edge - RD) % RP) == 0);
    samp.push_back(key_n);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("level", key_level, m_level);
    check("press", key_press, e_press);
    check("release", key_release, e_release);
    check("repeat", key_repeat, e_repeat);
    check("step", step, e_press | e_repeat);
    check("norep_level", z_level, m_level);
    check("norep_press", z_press, e_press);
    check("norep_release", z_release, e_release);
    check("norep_repeat", z_repeat, 1'b0);
    check("norep_step", z_step, e_press);
  endtask

  // One clock edge: advance the model, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic async_reset_check();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_level", key_level, 1'b0);
    check("async_rst_press", key_press, 1'b0);
    check("async_rst_release", key_release, 1'b0);
    check("async_rst_repeat", key_repeat, 1'b0);
    check("async_rst_step", step, 1'b0);
    check("async_rst_norep_level", z_level, 1'b0);
  endtask

  initial begin
    int z_press_cnt;
    int z_repeat_cnt;
    int len;
    rst = 1'b1;
    key_n = 1'b1;
    model_reset();

    // Reset state
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    tick();

    // Clean press: key_n low sampled at edge 1, accepted at edge 6
    key_n = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    check("clean_level_before_e6", key_level, 1'b0);
    tick();
    check("clean_press_e6", key_press, 1'b1);
    check("clean_step_e6", step, 1'b1);
    check("clean_level_e6", key_level, 1'b1);
    check("clean_repeat_e6", key_repeat, 1'b0);

    // Hold with repeat: first repeat 10 edges after press
    for (int rel = 1; rel <= 40; rel++) begin
      tick();
      if (rel == 1) check("press_one_cycle", key_press, 1'b0);
      if (rel == 9) check("no_repeat_rel9", key_repeat, 1'b0);
      if (rel == 10) check("first_repeat_rel10", key_repeat, 1'b1);
      if (rel == 13) check("second_repeat_rel13", key_repeat, 1'b1);
      if (rel == 14) check("repeat_one_cycle", key_repeat, 1'b0);
    end
    key_n = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    check("release_e6", key_release, 1'b1);
    check("release_level_e6", key_level, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_repeat_after_release", key_repeat, 1'b0);
    end

    // Bounce rejection
    key_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    key_n = 1'b1;
    tick();
    key_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    key_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bounce_level", key_level, 1'b0);
      check("bounce_step", step, 1'b0);
    end

    // Async reset mid-hold (in repeat phase)
    key_n = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    async_reset_check();
    tick();
    tick();
    #2 rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("post_rst_no_press", key_press, 1'b0);
    end
    tick();
    check("post_rst_press_e6", key_press, 1'b1);
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Release/repeat collision: press at edge p, release accepted at p+13
    key_n = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("coll_press", key_press, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    key_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) check("coll_repeat_p10", key_repeat, 1'b1);
    end
    check("coll_release", key_release, 1'b1);
    check("coll_repeat_suppressed", key_repeat, 1'b0);
    check("coll_step", step, 1'b0);
    for (int i = 0; i < 8; i++) tick();

    // Repeat disabled instance: long hold gives exactly one press
    z_press_cnt = 0;
    z_repeat_cnt = 0;
    key_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (z_press === 1'b1) z_press_cnt++;
      if (z_repeat === 1'b1) z_repeat_cnt++;
    end
    check("norep_one_press", (z_press_cnt == 1), 1'b1);
    check("norep_no_repeat", (z_repeat_cnt == 0), 1'b1);
    key_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Randomized segments, with occasional async reset
    for (int s = 0; s < 80; s++) begin
      key_n = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) tick();
      if ($urandom_range(0, 24) == 0) begin
        async_reset_check();
        tick();
        #2 rst = 1'b0;
      end
    end
    key_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
